// File: rtl/vcd_change_parser.sv
// VCD value-change parser: ASCII bytes in, one decoded
// time/scalar/vector event per line out, valid/ready on both sides.
module vcd_change_parser #(
   parameter  int TIME_W = 32,
   parameter  int VEC_W  = 16,
   parameter  int ID_MAX = 4,
   localparam int LEN_W  = $clog2(ID_MAX + 1)
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [7:0]          in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic                ev_valid,
   input  logic                ev_ready,
   output logic [1:0]          ev_kind,
   output logic [TIME_W-1:0]   ev_time,
   output logic [VEC_W-1:0]    ev_val,
   output logic [VEC_W-1:0]    ev_xz,
   output logic [8*ID_MAX-1:0] ev_id,
   output logic [LEN_W-1:0]    ev_id_len,
   output logic                err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TIME,
      S_SID,
      S_VBITS,
      S_VID,
      S_SKIP,
      S_EMIT
   } state_t;

   localparam int CNT_W = $clog2(VEC_W + 2);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(VEC_W + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(VEC_W);
   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(ID_MAX);

   state_t              r_state;
   logic [TIME_W-1:0]   r_time;
   logic [VEC_W-1:0]    r_val;
   logic [VEC_W-1:0]    r_xz;
   logic [8*ID_MAX-1:0] r_id;
   logic [LEN_W-1:0]    r_id_len;
   logic [1:0]          r_kind;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_lerr;
   logic                r_err;
   logic                r_valid;

   logic                w_take;
   logic                w_is_lf;
   logic                w_is_sp;
   logic                w_is_dig;
   logic                w_is_idc;
   logic                w_is_sbit;
   logic                w_is_vbit;
   logic                w_sval;
   logic                w_sxz;
   logic                w_vval;
   logic                w_vxz;
   logic [TIME_W+3:0]   w_t_ext;
   logic [TIME_W+3:0]   w_tnext;
   logic [CNT_W-1:0]    w_cnt_inc;

   assign in_ready  = (r_state != S_EMIT);
   assign ev_valid  = r_valid;
   assign ev_kind   = r_kind;
   assign ev_time   = r_time;
   assign ev_val    = r_val;
   assign ev_xz     = r_xz;
   assign ev_id     = r_id;
   assign ev_id_len = r_id_len;
   assign err       = r_err;

   // CR is dropped before any state sees it
   assign w_take = in_valid & in_ready & (in_data != 8'h0D);

   assign w_is_lf   = (in_data == 8'h0A);
   assign w_is_sp   = (in_data == 8'h20);
   assign w_is_dig  = (in_data >= 8'h30) && (in_data <= 8'h39);
   assign w_is_idc  = (in_data >= 8'h21) && (in_data <= 8'h7E);
   assign w_is_sbit = (in_data == 8'h30) || (in_data == 8'h31) ||
                      (in_data == 8'h78) || (in_data == 8'h58) ||
                      (in_data == 8'h7A) || (in_data == 8'h5A);
   assign w_is_vbit = (in_data == 8'h30) || (in_data == 8'h31) ||
                      (in_data == 8'h78) || (in_data == 8'h7A);
   assign w_sval    = (in_data == 8'h31) || (in_data == 8'h7A) ||
                      (in_data == 8'h5A);
   assign w_sxz     = (in_data == 8'h78) || (in_data == 8'h58) ||
                      (in_data == 8'h7A) || (in_data == 8'h5A);
   assign w_vval    = (in_data == 8'h31) || (in_data == 8'h7A);
   assign w_vxz     = (in_data == 8'h78) || (in_data == 8'h7A);

   // time*10 + digit with 4 guard bits to catch wrap
   assign w_t_ext = {4'b0000, r_time};
   assign w_tnext = (w_t_ext << 3) + (w_t_ext << 1) +
                    {{TIME_W{1'b0}}, in_data[3:0]};

   assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CNT_W'(1);

   // line FSM: builds the event fields in place, holds them in EMIT
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_time   <= '0;
         r_val    <= '0;
         r_xz     <= '0;
         r_id     <= '0;
         r_id_len <= '0;
         r_kind   <= '0;
         r_cnt    <= '0;
         r_lerr   <= 1'b0;
         r_err    <= 1'b0;
         r_valid  <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_take) begin
                  if (in_data == 8'h23) begin
                     r_state <= S_TIME;
                     r_time  <= '0;
                     r_cnt   <= '0;
                     r_lerr  <= 1'b0;
                  end else if (w_is_sbit) begin
                     r_state  <= S_SID;
                     r_val    <= {{(VEC_W-1){1'b0}}, w_sval};
                     r_xz     <= {{(VEC_W-1){1'b0}}, w_sxz};
                     r_id     <= '0;
                     r_id_len <= '0;
                     r_lerr   <= 1'b0;
                  end else if (in_data == 8'h62 || in_data == 8'h42) begin
                     r_state  <= S_VBITS;
                     r_val    <= '0;
                     r_xz     <= '0;
                     r_id     <= '0;
                     r_id_len <= '0;
                     r_cnt    <= '0;
                     r_lerr   <= 1'b0;
                  end else if (in_data == 8'h24) begin
                     r_state <= S_SKIP;
                  end else if (!w_is_lf) begin
                     r_state <= S_SKIP;
                     r_err   <= 1'b1;
                  end
               end
            end
            S_TIME: begin
               if (w_take) begin
                  if (w_is_dig) begin
                     r_time <= w_tnext[TIME_W-1:0];
                     r_cnt  <= w_cnt_inc;
                     if (|w_tnext[TIME_W+3:TIME_W]) r_lerr <= 1'b1;
                  end else if (w_is_lf) begin
                     if (r_cnt == '0 || r_lerr) begin
                        r_state <= S_IDLE;
                        r_err   <= 1'b1;
                     end else begin
                        r_state <= S_EMIT;
                        r_valid <= 1'b1;
                        r_kind  <= 2'd0;
                     end
                  end else begin
                     r_state <= S_SKIP;
                     r_err   <= 1'b1;
                  end
               end
            end
            S_VBITS: begin
               if (w_take) begin
                  if (w_is_vbit) begin
                     r_val <= {r_val[VEC_W-2:0], w_vval};
                     r_xz  <= {r_xz[VEC_W-2:0], w_vxz};
                     r_cnt <= w_cnt_inc;
                     if (r_cnt >= CNT_FULL) r_lerr <= 1'b1;
                  end else if (w_is_sp && r_cnt != '0) begin
                     r_state <= S_VID;
                  end else if (w_is_lf) begin
                     r_state <= S_IDLE;
                     r_err   <= 1'b1;
                  end else begin
                     r_state <= S_SKIP;
                     r_err   <= 1'b1;
                  end
               end
            end
            S_SID, S_VID: begin
               if (w_take) begin
                  if (w_is_idc) begin
                     if (r_id_len < LEN_MAX) begin
                        for (int i = 0; i < ID_MAX; i++) begin
                           if (r_id_len == LEN_W'(i)) r_id[i*8 +: 8] <= in_data;
                        end
                        r_id_len <= r_id_len + LEN_W'(1);
                     end else begin
                        r_lerr <= 1'b1;
                     end
                  end else if (w_is_lf) begin
                     if (r_id_len == '0 || r_lerr) begin
                        r_state <= S_IDLE;
                        r_err   <= 1'b1;
                     end else begin
                        r_state <= S_EMIT;
                        r_valid <= 1'b1;
                        r_kind  <= (r_state == S_VID) ? 2'd2 : 2'd1;
                     end
                  end else begin
                     r_state <= S_SKIP;
                     r_err   <= 1'b1;
                  end
               end
            end
            S_SKIP: begin
               if (w_take && w_is_lf) r_state <= S_IDLE;
            end
            S_EMIT: begin
               if (ev_ready) begin
                  r_state <= S_IDLE;
                  r_valid <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vcd_change_parser.sv
// Bench for vcd_change_parser: directed table, corner sequences,
// and random lines checked against a string-level line model.
module tb_vcd_change_parser;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        ev_valid;
   logic        ev_ready;
   logic [1:0]  ev_kind;
   logic [31:0] ev_time;
   logic [15:0] ev_val;
   logic [15:0] ev_xz;
   logic [31:0] ev_id;
   logic [2:0]  ev_id_len;
   logic        err;

   vcd_change_parser dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ev_valid  (ev_valid),
      .ev_ready  (ev_ready),
      .ev_kind   (ev_kind),
      .ev_time   (ev_time),
      .ev_val    (ev_val),
      .ev_xz     (ev_xz),
      .ev_id     (ev_id),
      .ev_id_len (ev_id_len),
      .err       (err)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      bit          has_ev;
      int          n_err;
      logic [1:0]  kind;
      logic [31:0] tm;
      logic [15:0] val;
      logic [15:0] xz;
      logic [31:0] id;
      logic [2:0]  len;
   } exp_t;

   typedef struct {
      string line;
      exp_t  e;
   } vec_t;

   typedef struct packed {
      logic [1:0]  kind;
      logic [31:0] tm;
      logic [15:0] val;
      logic [15:0] xz;
      logic [31:0] id;
      logic [2:0]  len;
   } ev_t;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   err_cnt = 0;
   ev_t  ev_q[$];
   bit   rnd_ready = 0;
   bit   rnd_gap = 0;
   ev_t  snap;
   bit   held = 0;
   vec_t tbl[$];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   function automatic ev_t grab();
      ev_t g;
      g.kind = ev_kind;
      g.tm   = ev_time;
      g.val  = ev_val;
      g.xz   = ev_xz;
      g.id   = ev_id;
      g.len  = ev_id_len;
      return g;
   endfunction

   // collect events and err pulses; a held event must not move
   always @(negedge clock) begin
      if (reset_n === 1'b1) begin
         if (err === 1'b1) err_cnt++;
         if (held) begin
            chk("hold_valid", 64'(ev_valid), 64'd1);
            chk("hold_stable", 64'(grab() == snap), 64'd1);
         end
         if (ev_valid === 1'b1 && ev_ready === 1'b1) ev_q.push_back(grab());
         held = (ev_valid === 1'b1) && (ev_ready === 1'b0);
         snap = grab();
      end else begin
         held = 0;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
      if (rnd_ready) ev_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send_byte(input byte b);
      int n;
      if (rnd_gap) begin
         in_valid = 1'b0;
         repeat ($urandom_range(0, 2)) tick();
      end
      in_data  = b;
      in_valid = 1'b1;
      n = 0;
      while (in_ready !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) chk("accept_timeout", 64'd0, 64'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic finish_line();
      int n;
      tick();
      n = 0;
      while (ev_valid === 1'b1 && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) chk("drain_timeout", 64'd0, 64'd1);
   endtask

   task automatic run_line(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
      finish_line();
   endtask

   task automatic check_line(input string tag, input exp_t e);
      ev_t g;
      chk({tag, ".events"}, 64'(ev_q.size()), 64'(e.has_ev));
      chk({tag, ".errs"}, 64'(err_cnt), 64'(e.n_err));
      if (ev_q.size() > 0 && e.has_ev) begin
         g = ev_q.pop_front();
         chk({tag, ".kind"}, 64'(g.kind), 64'(e.kind));
         if (e.kind == 2'd0) begin
            chk({tag, ".time"}, 64'(g.tm), 64'(e.tm));
         end else begin
            chk({tag, ".val"}, 64'(g.val), 64'(e.val));
            chk({tag, ".xz"}, 64'(g.xz), 64'(e.xz));
            chk({tag, ".id"}, 64'(g.id), 64'(e.id));
            chk({tag, ".len"}, 64'(g.len), 64'(e.len));
         end
      end
      ev_q.delete();
      err_cnt = 0;
   endtask

   function automatic exp_t mk(input bit ev, input int ne,
                               input int kind, input longint tm,
                               input int val, input int xz,
                               input longint id, input int len);
      exp_t e;
      e.has_ev = ev;
      e.n_err  = ne;
      e.kind   = kind[1:0];
      e.tm     = tm[31:0];
      e.val    = val[15:0];
      e.xz     = xz[15:0];
      e.id     = id[31:0];
      e.len    = len[2:0];
      return e;
   endfunction

   function automatic void add(input string s, input exp_t e);
      vec_t v;
      v.line = s;
      v.e    = e;
      tbl.push_back(v);
   endfunction

   // reference: identifier tail of a scalar/vector line
   function automatic exp_t id_part(input exp_t ei, input string t,
                                    input int st, input bit lerr);
      exp_t e;
      int   n;
      e = ei;
      n = t.len() - st;
      for (int i = st; i < t.len(); i++) begin
         if (t[i] < 8'h21 || t[i] > 8'h7E) begin
            e.n_err = 1;
            return e;
         end
      end
      if (n == 0 || n > 4 || lerr) begin
         e.n_err = 1;
         return e;
      end
      e.id = '0;
      for (int j = 0; j < n; j++) e.id[j*8 +: 8] = t[st+j];
      e.len    = n[2:0];
      e.has_ev = 1;
      return e;
   endfunction

   // reference: whole line as text -> expected event / error count
   function automatic exp_t model(input string s);
      exp_t            e;
      string           t;
      byte             c;
      longint unsigned v;
      bit              ov;
      int              sp;
      e = '0;
      t = "";
      for (int i = 0; i < s.len(); i++)
         if (s[i] != 8'h0D && s[i] != 8'h0A) t = {t, $sformatf("%c", s[i])};
      if (t.len() == 0) return e;
      c = t[0];
      if (c == "#") begin
         if (t.len() == 1) begin
            e.n_err = 1;
            return e;
         end
         v = 0;
         ov = 0;
         for (int i = 1; i < t.len(); i++) begin
            c = t[i];
            if (c < "0" || c > "9") begin
               e.n_err = 1;
               return e;
            end
            v = v * 10 + longint'(c - "0");
            if (v >= 64'h1_0000_0000) begin
               ov = 1;
               v = v % 64'h1_0000_0000;
            end
         end
         if (ov) begin
            e.n_err = 1;
            return e;
         end
         e.has_ev = 1;
         e.kind = 0;
         e.tm = v[31:0];
         return e;
      end
      if (c == "0" || c == "1" || c == "x" || c == "X" ||
          c == "z" || c == "Z") begin
         e.val  = (c == "1" || c == "z" || c == "Z") ? 16'd1 : 16'd0;
         e.xz   = (c == "0" || c == "1") ? 16'd0 : 16'd1;
         e.kind = 1;
         return id_part(e, t, 1, 0);
      end
      if (c == "b" || c == "B") begin
         sp = -1;
         for (int i = 1; i < t.len(); i++) begin
            c = t[i];
            if (c == " ") begin
               sp = i;
               break;
            end
            if (!(c == "0" || c == "1" || c == "x" || c == "z")) begin
               e.n_err = 1;
               return e;
            end
         end
         if (sp < 2) begin
            e.n_err = 1;
            return e;
         end
         for (int i = 1; i < sp; i++) begin
            c = t[i];
            e.val = {e.val[14:0], (c == "1" || c == "z")};
            e.xz  = {e.xz[14:0], (c == "x" || c == "z")};
         end
         e.kind = 2;
         return id_part(e, t, sp + 1, (sp - 1) > 16);
      end
      if (c == "$") return e;
      e.n_err = 1;
      return e;
   endfunction

   function automatic string pick(input string set);
      return $sformatf("%c", set[$urandom_range(0, set.len() - 1)]);
   endfunction

   function automatic string rnd_id();
      string s;
      s = "";
      repeat ($urandom_range(0, 5))
         s = {s, $sformatf("%c", 8'($urandom_range(33, 126)))};
      return s;
   endfunction

   function automatic string gen_line();
      string s;
      int    k;
      k = $urandom_range(0, 9);
      s = "";
      case (k)
         0, 1, 9: begin
            s = "#";
            repeat ($urandom_range(0, 11)) s = {s, pick("0123456789")};
            if ($urandom_range(0, 15) == 0) s = {s, "q"};
         end
         2, 3: begin
            s = {pick("01xXzZ"), rnd_id()};
            if ($urandom_range(0, 11) == 0) s = {s, " "};
         end
         4, 5: begin
            s = "b";
            repeat ($urandom_range(0, 18)) begin
               if ($urandom_range(0, 29) == 0) s = {s, "X"};
               else s = {s, pick("01xz")};
            end
            if ($urandom_range(0, 9) != 0) s = {s, " "};
            s = {s, rnd_id()};
         end
         6: s = "$upscope";
         7: s = {pick("qA9 !"), rnd_id()};
         default: s = "";
      endcase
      if ($urandom_range(0, 7) == 0) begin
         if ($urandom_range(0, 1) == 0) s = {"\r", s};
         else s = {s, "\r"};
      end
      return {s, "\n"};
   endfunction

   initial begin
      string s;
      reset_n  = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      ev_ready = 1'b1;
      tick();
      tick();
      chk("rst.ev_valid", 64'(ev_valid), 64'd0);
      chk("rst.err", 64'(err), 64'd0);
      chk("rst.in_ready", 64'(in_ready), 64'd1);
      chk("rst.fields", 64'(grab() == ev_t'('0)), 64'd1);
      reset_n = 1'b1;
      tick();

      // latency: valid one cycle after LF, single cycle with ready=1
      send_byte("#");
      send_byte("1");
      send_byte("0");
      send_byte(8'h0A);
      chk("lat.valid", 64'(ev_valid), 64'd1);
      chk("lat.in_ready", 64'(in_ready), 64'd0);
      chk("lat.time", 64'(ev_time), 64'd10);
      tick();
      chk("lat.valid_drop", 64'(ev_valid), 64'd0);
      chk("lat.in_ready_back", 64'(in_ready), 64'd1);
      finish_line();
      check_line("lat", mk(1, 0, 0, 10, 0, 0, 0, 0));

      // back-pressure: event held, input stalled, LF offered meanwhile
      ev_ready = 1'b0;
      send_byte("#");
      send_byte("7");
      send_byte(8'h0A);
      in_data  = 8'h0A;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("bp.valid", 64'(ev_valid), 64'd1);
         chk("bp.in_ready", 64'(in_ready), 64'd0);
         chk("bp.time", 64'(ev_time), 64'd7);
         chk("bp.kind", 64'(ev_kind), 64'd0);
         tick();
      end
      ev_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("bp.in_ready_back", 64'(in_ready), 64'd1);
      chk("bp.valid_drop", 64'(ev_valid), 64'd0);
      finish_line();
      check_line("bp", mk(1, 0, 0, 7, 0, 0, 0, 0));

      // reset in the middle of a vector line
      send_byte("b");
      send_byte("1");
      send_byte("0");
      send_byte("1");
      reset_n = 1'b0;
      tick();
      chk("mrst.ev_valid", 64'(ev_valid), 64'd0);
      chk("mrst.err", 64'(err), 64'd0);
      chk("mrst.in_ready", 64'(in_ready), 64'd1);
      chk("mrst.fields", 64'(grab() == ev_t'('0)), 64'd1);
      reset_n = 1'b1;
      ev_q.delete();
      err_cnt = 0;
      tick();
      run_line("#5\n");
      check_line("mrst", mk(1, 0, 0, 5, 0, 0, 0, 0));

      // directed table
      add("#10\n",              mk(1, 0, 0, 10, 0, 0, 0, 0));
      add("1!\n",               mk(1, 0, 1, 0, 1, 0, 'h21, 1));
      add("z\"\n",              mk(1, 0, 1, 0, 1, 1, 'h22, 1));
      add("b10x1 #a\n",         mk(1, 0, 2, 0, 'h9, 'h2, 'h6123, 2));
      add("q12\n",              mk(0, 1, 0, 0, 0, 0, 0, 0));
      add("#3\n",               mk(1, 0, 0, 3, 0, 0, 0, 0));
      add("1abcde\n",           mk(0, 1, 0, 0, 0, 0, 0, 0));
      add("#3\n",               mk(1, 0, 0, 3, 0, 0, 0, 0));
      add("#4294967296\n",      mk(0, 1, 0, 0, 0, 0, 0, 0));
      add("#3\n",               mk(1, 0, 0, 3, 0, 0, 0, 0));
      add("$upscope\n",         mk(0, 0, 0, 0, 0, 0, 0, 0));
      add("#3\n",               mk(1, 0, 0, 3, 0, 0, 0, 0));
      add("\n",                 mk(0, 0, 0, 0, 0, 0, 0, 0));
      add("#4294967295\r\n",    mk(1, 0, 0, 'hFFFFFFFF, 0, 0, 0, 0));
      add("x%\n",               mk(1, 0, 1, 0, 0, 1, 'h25, 1));
      add("b1111000011110000z abc\n", mk(0, 1, 0, 0, 0, 0, 0, 0));
      add("b1 \n",              mk(0, 1, 0, 0, 0, 0, 0, 0));
      add("0ab cd\n",           mk(0, 1, 0, 0, 0, 0, 0, 0));
      add("#\n",                mk(0, 1, 0, 0, 0, 0, 0, 0));
      add("1wxyz\n",            mk(1, 0, 1, 0, 1, 0, 'h7a797877, 4));
      add("bzx01 ~\n",          mk(1, 0, 2, 0, 'h9, 'hC, 'h7e, 1));
      add("#1a\n",              mk(0, 1, 0, 0, 0, 0, 0, 0));
      add("b1111000011110000 Q\n", mk(1, 0, 2, 0, 'hF0F0, 0, 'h51, 1));
      for (int i = 0; i < tbl.size(); i++) begin
         run_line(tbl[i].line);
         check_line($sformatf("vec%0d", i), tbl[i].e);
      end

      // random lines, random gaps and consumer stalls
      rnd_ready = 1;
      rnd_gap   = 1;
      for (int i = 0; i < 250; i++) begin
         s = gen_line();
         run_line(s);
         check_line($sformatf("rnd%0d", i), model(s));
      end
      rnd_ready = 0;
      ev_ready  = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
